// File: rtl/matrix_pkg.sv
// ---------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the matrix row packer / decompiler pair.
//   MAX_ELEMENT_SIZE : default bits per matrix element
//   MAX_SIZE_A       : default elements per row word (columns per row)
//   MAX_SIZE_B       : default row words per matrix (rows per matrix)
//   decomp_state_t   : occupancy of the decompiler's two row buffers
//   isPow2AtLeast2   : elaboration-time helper for sizing checks
// ---------------------------------------------------------------------------
package matrix_pkg;

   localparam int MAX_ELEMENT_SIZE = 8;
   localparam int MAX_SIZE_A       = 32;
   localparam int MAX_SIZE_B       = 32;

   // EMPTY: no row held, ONE: shifter loaded, FULL: shifter and hold loaded
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } decomp_state_t;

   // Counters are sized with $clog2 and wrap naturally, so the dimensions
   // must be powers of two and at least 2 for the index widths to be non-zero.
   function automatic bit isPow2AtLeast2(input int value);
      return (value >= 2) && ((value & (value - 1)) == 0);
   endfunction

endpackage

// File: rtl/row_shift_unloader.sv
// ---------------------------------------------------------------------------
// row_shift_unloader
// Holds one packed row in a shift register and presents it one element per
// handshake, most-significant element first, with its column index.
//   i_clk, i_rst   : clock and asynchronous active-high reset
//   i_flush        : synchronous clear of shifter, column and valid
//   i_load         : load i_loadRow into the shifter, column 0, valid set
//   i_loadRow      : packed row, column 0 in the MSBs
//   i_readyIn      : downstream accepts the current element
//   o_element      : current element (shifter MSBs)
//   o_colAddr      : column index of o_element
//   o_valid        : o_element / o_colAddr are valid
//   o_xfer         : element transfer happens at the coming edge
//   o_lastCol      : current element is the final column of its row
// ---------------------------------------------------------------------------
module row_shift_unloader #(
   parameter int E = 8,
   parameter int A = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_flush,
   input  logic                 i_load,
   input  logic [E*A-1:0]       i_loadRow,
   input  logic                 i_readyIn,
   output logic [E-1:0]         o_element,
   output logic [$clog2(A)-1:0] o_colAddr,
   output logic                 o_valid,
   output logic                 o_xfer,
   output logic                 o_lastCol
);

   localparam int              CW       = $clog2(A);
   localparam logic [CW-1:0]   LAST_COL = CW'(A - 1);

   logic [E*A-1:0] r_shifter;
   logic [CW-1:0]  r_colAddr;
   logic           r_valid;
   logic           w_xfer;
   logic           w_lastCol;

   // An element leaves whenever something is presented and downstream takes
   // it; everything below only moves on such a transfer, which is what keeps
   // the outputs frozen while the consumer stalls.
   assign w_xfer    = r_valid & i_readyIn;
   assign w_lastCol = (r_colAddr == LAST_COL);

   // Shifter, column counter and valid flag. A load wins over the normal
   // advance because the top only loads when the shifter is empty or is
   // handing off its final column in this very cycle. On the final column
   // without a load the row is exhausted, so valid drops and the column
   // wraps to 0 ready for the next row.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_shifter <= '0;
         r_colAddr <= '0;
         r_valid   <= 1'b0;
      end else if (i_flush) begin
         r_shifter <= '0;
         r_colAddr <= '0;
         r_valid   <= 1'b0;
      end else if (i_load) begin
         r_shifter <= i_loadRow;
         r_colAddr <= '0;
         r_valid   <= 1'b1;
      end else if (w_xfer) begin
         if (w_lastCol) begin
            r_colAddr <= '0;
            r_valid   <= 1'b0;
         end else begin
            r_shifter <= {r_shifter[E*A-E-1:0], {E{1'b0}}};
            r_colAddr <= r_colAddr + CW'(1);
         end
      end
   end

   assign o_element = r_shifter[E*A-1 -: E];
   assign o_colAddr = r_colAddr;
   assign o_valid   = r_valid;
   assign o_xfer    = w_xfer;
   assign o_lastCol = w_lastCol;

endmodule

// File: rtl/matrix_decompiler.sv
// ---------------------------------------------------------------------------
// matrix_decompiler
// Turns packed matrix row words back into a stream of single elements tagged
// with (row_addr, col_addr). One row is unloaded from a shifter while the
// next waits in a hold register, so consecutive rows stream with no bubble.
//   inter_refclk    : sole clock, rising edge
//   rst             : asynchronous active-high reset
//   flush           : synchronous clear of buffers, counters and valid
//   row_in          : packed row, column c at [E*A-1-E*c -: E]
//   valid_row_in    : row_in valid
//   ready_row_in    : a row can be taken this cycle
//   matrix_element  : current element
//   row_addr        : row index of matrix_element
//   col_addr        : column index of matrix_element
//   valid_data_out  : element outputs valid
//   ready_in        : downstream accepts the element
//   last_out        : element is the final one of the matrix
// ---------------------------------------------------------------------------
module matrix_decompiler #(
   parameter int MAX_ELEMENT_SIZE = matrix_pkg::MAX_ELEMENT_SIZE,
   parameter int MAX_SIZE_A       = matrix_pkg::MAX_SIZE_A,
   parameter int MAX_SIZE_B       = matrix_pkg::MAX_SIZE_B
) (
   input  logic                                 inter_refclk,
   input  logic                                 rst,
   input  logic                                 flush,
   input  logic [MAX_ELEMENT_SIZE*MAX_SIZE_A-1:0] row_in,
   input  logic                                 valid_row_in,
   output logic                                 ready_row_in,
   output logic [MAX_ELEMENT_SIZE-1:0]          matrix_element,
   output logic [$clog2(MAX_SIZE_B)-1:0]        row_addr,
   output logic [$clog2(MAX_SIZE_A)-1:0]        col_addr,
   output logic                                 valid_data_out,
   input  logic                                 ready_in,
   output logic                                 last_out
);

   import matrix_pkg::*;

   localparam int            E        = MAX_ELEMENT_SIZE;
   localparam int            A        = MAX_SIZE_A;
   localparam int            B        = MAX_SIZE_B;
   localparam int            RW       = $clog2(B);
   localparam logic [RW-1:0] LAST_ROW = RW'(B - 1);

   // The wrap-around counters only work for power-of-two dimensions.
   if (!isPow2AtLeast2(A) || !isPow2AtLeast2(B)) begin : gBadParams
      $error("matrix_decompiler: MAX_SIZE_A and MAX_SIZE_B must be powers of two >= 2");
   end

   decomp_state_t  r_state;
   decomp_state_t  w_nextState;
   logic [E*A-1:0] r_holdRow;
   logic [RW-1:0]  r_rowAddr;
   logic           w_rowXfer;
   logic           w_elemXfer;
   logic           w_lastCol;
   logic           w_rowDone;
   logic           w_load;
   logic           w_loadFromHold;
   logic           w_captureHold;
   logic [E*A-1:0] w_loadRow;
   logic           w_valid;

   // A row can be accepted unless both buffers are occupied. Since reset
   // returns the state to EMPTY, this is also high during reset.
   assign ready_row_in = (r_state != FULL);
   assign w_rowXfer    = valid_row_in & ready_row_in;
   assign w_rowDone    = w_elemXfer & w_lastCol;

   // Next-state and buffer steering. When the shifter hands off its last
   // column, the replacement row comes from hold if one is waiting, or
   // straight from the input if a row arrives in that same cycle; either
   // way the shifter reloads on the same edge, so there is no bubble.
   always_comb begin
      w_nextState    = r_state;
      w_load         = 1'b0;
      w_loadFromHold = 1'b0;
      w_captureHold  = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_rowXfer) begin
               w_load      = 1'b1;
               w_nextState = ONE;
            end
         end
         ONE: begin
            if (w_rowDone) begin
               if (w_rowXfer) begin
                  w_load = 1'b1;
               end else begin
                  w_nextState = EMPTY;
               end
            end else if (w_rowXfer) begin
               w_captureHold = 1'b1;
               w_nextState   = FULL;
            end
         end
         FULL: begin
            if (w_rowDone) begin
               w_load         = 1'b1;
               w_loadFromHold = 1'b1;
               w_nextState    = ONE;
            end
         end
         default: begin
            w_nextState = EMPTY;
         end
      endcase
   end

   assign w_loadRow = w_loadFromHold ? r_holdRow : row_in;

   // State register; flush abandons whatever is buffered.
   always_ff @(posedge inter_refclk or posedge rst) begin
      if (rst) begin
         r_state <= EMPTY;
      end else if (flush) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Hold register for the row queued behind the one being unloaded.
   always_ff @(posedge inter_refclk or posedge rst) begin
      if (rst) begin
         r_holdRow <= '0;
      end else if (flush) begin
         r_holdRow <= '0;
      end else if (w_captureHold) begin
         r_holdRow <= row_in;
      end
   end

   // Row counter advances as the final column of a row is handed over and
   // wraps after the final row, so the next matrix starts at row 0.
   always_ff @(posedge inter_refclk or posedge rst) begin
      if (rst) begin
         r_rowAddr <= '0;
      end else if (flush) begin
         r_rowAddr <= '0;
      end else if (w_rowDone) begin
         if (r_rowAddr == LAST_ROW) begin
            r_rowAddr <= '0;
         end else begin
            r_rowAddr <= r_rowAddr + RW'(1);
         end
      end
   end

   row_shift_unloader #(
      .E (E),
      .A (A)
   ) uUnloader (
      .i_clk     (inter_refclk),
      .i_rst     (rst),
      .i_flush   (flush),
      .i_load    (w_load),
      .i_loadRow (w_loadRow),
      .i_readyIn (ready_in),
      .o_element (matrix_element),
      .o_colAddr (col_addr),
      .o_valid   (w_valid),
      .o_xfer    (w_elemXfer),
      .o_lastCol (w_lastCol)
   );

   assign valid_data_out = w_valid;
   assign row_addr       = r_rowAddr;

   // End of matrix is the final column of the final row, flagged alongside
   // the element itself.
   assign last_out = w_valid & w_lastCol & (r_rowAddr == LAST_ROW);

endmodule

// File: tb/tb_matrix_decompiler.sv
// ---------------------------------------------------------------------------
// tb_matrix_decompiler
// Directed bench for matrix_decompiler with E=8, A=4, B=4.
// ---------------------------------------------------------------------------
module tb_matrix_decompiler;

   localparam int E = 8;
   localparam int A = 4;
   localparam int B = 4;

   logic              inter_refclk = 1'b0;
   logic              rst;
   logic              flush;
   logic [E*A-1:0]    row_in;
   logic              valid_row_in;
   logic              ready_row_in;
   logic [E-1:0]      matrix_element;
   logic [1:0]        row_addr;
   logic [1:0]        col_addr;
   logic              valid_data_out;
   logic              ready_in;
   logic              last_out;

   int errors = 0;
   int checks = 0;

   matrix_decompiler #(
      .MAX_ELEMENT_SIZE (E),
      .MAX_SIZE_A       (A),
      .MAX_SIZE_B       (B)
   ) dut (
      .inter_refclk   (inter_refclk),
      .rst            (rst),
      .flush          (flush),
      .row_in         (row_in),
      .valid_row_in   (valid_row_in),
      .ready_row_in   (ready_row_in),
      .matrix_element (matrix_element),
      .row_addr       (row_addr),
      .col_addr       (col_addr),
      .valid_data_out (valid_data_out),
      .ready_in       (ready_in),
      .last_out       (last_out)
   );

   // Free-running clock, 10 time units per period.
   always #5 inter_refclk = ~inter_refclk;

   // Safety net so the run always ends even if something locks up.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge inter_refclk);
      #1;
   endtask

   task automatic applyStimulus(input logic [E*A-1:0] row, input logic vRow,
                                input logic rdy, input logic fl);
      row_in       = row;
      valid_row_in = vRow;
      ready_in     = rdy;
      flush        = fl;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkElem(input string tag, input logic [7:0] e, input logic [1:0] r,
                            input logic [1:0] c, input logic l);
      checkOutput(tag, 64'({valid_data_out, matrix_element, row_addr, col_addr, last_out}),
                  64'({1'b1, e, r, c, l}));
   endtask

   task automatic checkIdle(input string tag);
      checkOutput(tag, 64'({valid_data_out, last_out}), 64'd0);
   endtask

   // Streams four rows whose element (r,c) is base + 16*r + c with ready_in
   // held high, checking nElems consecutive elements; a full matrix also
   // checks that the output goes idle afterwards.
   task automatic playMatrix(input logic [7:0] base, input int nElems, input string tag);
      logic [31:0] rows [4];
      int          rowIdx;
      logic        acc;
      for (int r = 0; r < 4; r++) begin
         rows[r] = {base + 8'(16*r), base + 8'(16*r + 1), base + 8'(16*r + 2), base + 8'(16*r + 3)};
      end
      rowIdx = 0;
      applyStimulus(rows[0], 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < nElems; k++) begin
         acc = ready_row_in & valid_row_in;
         tick();
         if (acc) begin
            rowIdx++;
            if (rowIdx < 4) row_in = rows[rowIdx];
            else valid_row_in = 1'b0;
         end
         checkElem(tag, base + 8'(16*(k/4) + (k%4)), 2'(k/4), 2'(k%4), (k == 15));
      end
      if (nElems == 16) begin
         tick();
         checkIdle({tag, " end"});
      end
   endtask

   initial begin
      logic [31:0] t4Row;
      logic [31:0] t5Rows [3];
      int          rowIdx;
      logic        acc;

      // ---- 1: reset, then a reset pulse in the middle of a row ----
      rst = 1'b1;
      applyStimulus('0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("reset outputs", 64'({valid_data_out, last_out, matrix_element, row_addr, col_addr}), 64'd0);
      checkOutput("reset ready", 64'(ready_row_in), 64'd1);
      rst = 1'b0;
      applyStimulus(32'h11223344, 1'b1, 1'b1, 1'b0);
      tick();
      applyStimulus('0, 1'b0, 1'b1, 1'b0);
      checkElem("t1 col0", 8'h11, 2'd0, 2'd0, 1'b0);
      tick();
      checkElem("t1 col1", 8'h22, 2'd0, 2'd1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      checkIdle("t1 reset idle");
      checkOutput("t1 reset ready", 64'(ready_row_in), 64'd1);
      checkOutput("t1 reset addr", 64'({row_addr, col_addr}), 64'd0);
      tick();
      rst = 1'b0;

      // ---- 2: single row, four elements then idle ----
      applyStimulus(32'hAABBCCDD, 1'b1, 1'b1, 1'b0);
      tick();
      applyStimulus('0, 1'b0, 1'b1, 1'b0);
      checkElem("t2 e0", 8'hAA, 2'd0, 2'd0, 1'b0);
      tick();
      checkElem("t2 e1", 8'hBB, 2'd0, 2'd1, 1'b0);
      tick();
      checkElem("t2 e2", 8'hCC, 2'd0, 2'd2, 1'b0);
      tick();
      checkElem("t2 e3", 8'hDD, 2'd0, 2'd3, 1'b0);
      tick();
      checkIdle("t2 idle");

      // Row counter is now 1; flush returns it to 0.
      applyStimulus('0, 1'b0, 1'b1, 1'b1);
      tick();
      applyStimulus('0, 1'b0, 1'b1, 1'b0);
      checkOutput("flush row addr", 64'({row_addr, col_addr}), 64'd0);

      // ---- 3: full matrix, back-to-back rows ----
      playMatrix(8'h00, 16, "t3 stream");

      // ---- 4: ready_in toggling ----
      t4Row = 32'hA1B2C3D4;
      applyStimulus(t4Row, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus('0, 1'b0, 1'b0, 1'b0);
      checkElem("t4 load", t4Row[31 -: 8], 2'd0, 2'd0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         ready_in = 1'b0;
         tick();
         checkElem("t4 hold", t4Row[31-8*c -: 8], 2'd0, 2'(c), 1'b0);
         ready_in = 1'b1;
         tick();
         if (c < 3) checkElem("t4 next", t4Row[31-8*(c+1) -: 8], 2'd0, 2'(c+1), 1'b0);
         else checkIdle("t4 idle");
      end

      // ---- 5: stalled output, row backpressure ----
      t5Rows[0] = 32'h5A5B5C5D;
      t5Rows[1] = 32'h6A6B6C6D;
      t5Rows[2] = 32'h7A7B7C7D;
      applyStimulus(t5Rows[0], 1'b1, 1'b0, 1'b0);
      checkOutput("t5 ready empty", 64'(ready_row_in), 64'd1);
      tick();
      applyStimulus(t5Rows[1], 1'b1, 1'b0, 1'b0);
      checkOutput("t5 ready one", 64'(ready_row_in), 64'd1);
      tick();
      checkOutput("t5 ready full", 64'(ready_row_in), 64'd0);
      applyStimulus(t5Rows[2], 1'b1, 1'b0, 1'b0);
      for (int s = 0; s < 3; s++) begin
         tick();
         checkElem("t5 stall elem", 8'h5A, 2'd1, 2'd0, 1'b0);
         checkOutput("t5 stall ready", 64'(ready_row_in), 64'd0);
      end
      rowIdx = 2;
      ready_in = 1'b1;
      for (int k = 1; k < 12; k++) begin
         acc = ready_row_in & valid_row_in;
         tick();
         if (acc) begin
            rowIdx++;
            valid_row_in = 1'b0;
         end
         checkElem("t5 drain", t5Rows[k/4][31-8*(k%4) -: 8], 2'(1 + k/4), 2'(k%4), (k == 11));
      end
      tick();
      checkIdle("t5 idle");
      checkOutput("t5 third row taken", 64'(rowIdx), 64'd3);

      // ---- 6: flush at element (1,2), then a clean matrix ----
      playMatrix(8'h40, 7, "t6 pre");
      flush = 1'b1;
      tick();
      applyStimulus('0, 1'b0, 1'b1, 1'b0);
      checkIdle("t6 flushed");
      checkOutput("t6 flushed addr", 64'({row_addr, col_addr}), 64'd0);
      checkOutput("t6 flushed ready", 64'(ready_row_in), 64'd1);
      tick();
      checkIdle("t6 nothing held");
      playMatrix(8'h80, 16, "t6 post");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
